// File: rtl/shift_arbiter.sv
// Two-port round-robin arbiter in front of one SLL/SRL/SRA barrel shifter, result held in a one-entry tagged buffer.
// Latency: one cycle from accept to o_rsp_valid. Backpressure: a full buffer with i_rsp_ready low drops both readys.
// Readys are combinational on the valids; the buffer is refilled in the same cycle it drains.
module shift_arbiter #(
    parameter int N = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_req0_valid,
    output logic         o_req0_ready,
    input  logic [1:0]   i_req0_op,
    input  logic [N-1:0] i_req0_a,
    input  logic [N-1:0] i_req0_b,
    input  logic         i_req1_valid,
    output logic         o_req1_ready,
    input  logic [1:0]   i_req1_op,
    input  logic [N-1:0] i_req1_a,
    input  logic [N-1:0] i_req1_b,
    output logic         o_rsp_valid,
    input  logic         i_rsp_ready,
    output logic         o_rsp_id,
    output logic [N-1:0] o_rsp_data,
    output logic         o_busy
);
    localparam int SHW = $clog2(N);

    logic         rsp_vld_q, rsp_vld_d;
    logic         rsp_id_q, rsp_id_d;
    logic [N-1:0] rsp_dat_q, rsp_dat_d;
    logic         last_grant_q, last_grant_d;

    logic           gnt_vld;
    logic           gnt_id;
    logic           can_load;
    logic           accept;
    logic [1:0]     sel_op;
    logic [N-1:0]   sel_a;
    logic [SHW-1:0] sel_sh;
    logic [N-1:0]   shift_res;

    always_comb begin
        gnt_vld  = i_req0_valid | i_req1_valid;
        // On a tie the requester that did not win last time goes next.
        gnt_id   = (i_req0_valid && i_req1_valid) ? ~last_grant_q : i_req1_valid;
        can_load = !rsp_vld_q || i_rsp_ready;
        accept   = !i_rst && can_load && gnt_vld;

        o_req0_ready = accept && !gnt_id;
        o_req1_ready = accept && gnt_id;

        sel_op = gnt_id ? i_req1_op : i_req0_op;
        sel_a  = gnt_id ? i_req1_a  : i_req0_a;
        sel_sh = gnt_id ? i_req1_b[SHW-1:0] : i_req0_b[SHW-1:0];
    end

    always_comb begin
        shift_res = sel_a;
        case (sel_op)
            2'b00:   shift_res = sel_a << sel_sh;
            2'b01:   shift_res = sel_a >> sel_sh;
            2'b10:   shift_res = $signed(sel_a) >>> sel_sh;
            default: shift_res = sel_a;
        endcase
    end

    always_comb begin
        rsp_vld_d    = rsp_vld_q;
        rsp_id_d     = rsp_id_q;
        rsp_dat_d    = rsp_dat_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            rsp_vld_d    = 1'b1;
            rsp_id_d     = gnt_id;
            rsp_dat_d    = shift_res;
            last_grant_d = gnt_id;
        end else if (i_rsp_ready) begin
            rsp_vld_d = 1'b0;
        end
    end

    // last_grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rsp_vld_q    <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_dat_q    <= '0;
            last_grant_q <= 1'b1;
        end else begin
            rsp_vld_q    <= rsp_vld_d;
            rsp_id_q     <= rsp_id_d;
            rsp_dat_q    <= rsp_dat_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign o_rsp_valid = rsp_vld_q;
    assign o_rsp_id    = rsp_id_q;
    assign o_rsp_data  = rsp_dat_q;
    assign o_busy      = rsp_vld_q | i_req0_valid | i_req1_valid;

endmodule
